// File: rtl/usr_burst_nb.sv
// usr_burst_nb: n-bit universal shift register with rotate, arithmetic shift,
// serial taps and a counted burst mode (busy/done handshake, abort).
//
// Ports:
//   clk      rising-edge clock
//   clr_n    asynchronous active-low reset
//   op       operation select (0 hold, 1 load, 2 shl, 3 shr, 4 rotl,
//            5 rotr, 6 asr, 7 burst start); only acted on in IDLE
//   data_in  parallel load value
//   dbit     serial fill bit for logical shifts (including burst steps)
//   cnt      burst length, sampled on burst start
//   bdir     burst direction (0 left, 1 right), sampled on burst start
//   abort    ends a running burst with no shift and no done
//   data_out register contents
//   sout_l   data_out[n-1] (combinational tap)
//   sout_r   data_out[0]   (combinational tap)
//   busy     high while a burst is running
//   done     one-cycle pulse after a burst completes normally
module usr_burst_nb #(
    parameter int unsigned n  = 8,
    parameter int unsigned cw = $clog2(n + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [2:0]    op,
    input  logic [n-1:0]  data_in,
    input  logic          dbit,
    input  logic [cw-1:0] cnt,
    input  logic          bdir,
    input  logic          abort,
    output logic [n-1:0]  data_out,
    output logic          sout_l,
    output logic          sout_r,
    output logic          busy,
    output logic          done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_SHR   = 3'd3;
    localparam logic [2:0] OP_ROTL  = 3'd4;
    localparam logic [2:0] OP_ROTR  = 3'd5;
    localparam logic [2:0] OP_ASR   = 3'd6;
    localparam logic [2:0] OP_BURST = 3'd7;

    state_t          state_q, state_d;
    logic [cw-1:0]   rem_q, rem_d;
    logic            dir_q, dir_d;
    logic [n-1:0]    data_d;
    logic            busy_d;
    logic            done_d;
    logic [n-1:0]    shl_fill;
    logic [n-1:0]    shr_fill;
    logic            last_step;

    assign shl_fill  = {data_out[n-2:0], dbit};
    assign shr_fill  = {dbit, data_out[n-1:1]};
    assign last_step = (rem_q == cw'(1));

    // State and registered outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            data_out <= data_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next state: abort takes priority over the final step
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (op == OP_BURST && cnt != '0) state_d = RUN;
            RUN:  if (abort || last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        data_d = data_out;
        rem_d  = rem_q;
        dir_d  = dir_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                case (op)
                    OP_LOAD:  data_d = data_in;
                    OP_SHL:   data_d = shl_fill;
                    OP_SHR:   data_d = shr_fill;
                    OP_ROTL:  data_d = {data_out[n-2:0], data_out[n-1]};
                    OP_ROTR:  data_d = {data_out[0], data_out[n-1:1]};
                    OP_ASR:   data_d = {data_out[n-1], data_out[n-1:1]};
                    OP_BURST: begin
                        // zero-length burst completes immediately
                        if (cnt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d = cnt;
                            dir_d = bdir;
                        end
                    end
                    default: ;
                endcase
            end
            RUN: begin
                if (abort) begin
                    rem_d = '0;
                end else begin
                    data_d = dir_q ? shr_fill : shl_fill;
                    rem_d  = rem_q - cw'(1);
                    done_d = last_step;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == RUN);
    end

    assign sout_l = data_out[n-1];
    assign sout_r = data_out[0];

endmodule

// File: tb/tb_usr_burst_nb.sv
// Bench for usr_burst_nb: directed vectors, literal expectations and a
// per-cycle comparison against a behavioural model.
module tb_usr_burst_nb;

    localparam int unsigned N    = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned MASK = (1 << N) - 1;

    logic          clk;
    logic          clr_n;
    logic [2:0]    op;
    logic [N-1:0]  data_in;
    logic          dbit;
    logic [CW-1:0] cnt;
    logic          bdir;
    logic          abort;
    logic [N-1:0]  data_out;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    int n_pass = 0;
    int n_total = 0;

    usr_burst_nb #(.n(N), .cw(CW)) dut (
        .clk(clk), .clr_n(clr_n), .op(op), .data_in(data_in), .dbit(dbit),
        .cnt(cnt), .bdir(bdir), .abort(abort), .data_out(data_out),
        .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: register value plus number of burst steps left
    int unsigned m_data;
    int unsigned m_left;
    logic        m_dir;
    logic        m_done;

    always @(posedge clk or negedge clr_n) begin
        int unsigned d;
        int unsigned l;
        logic        dn;
        logic        dr;
        if (!clr_n) begin
            m_data <= 0;
            m_left <= 0;
            m_dir  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            d  = m_data;
            l  = m_left;
            dr = m_dir;
            dn = 1'b0;
            if (l > 0) begin
                if (abort) l = 0;
                else begin
                    if (dr) d = (d >> 1) | (int'(dbit) << (N - 1));
                    else    d = ((d << 1) | int'(dbit)) & MASK;
                    l = l - 1;
                    dn = (l == 0);
                end
            end else begin
                case (op)
                    3'd1: d = int'(data_in);
                    3'd2: d = ((d << 1) | int'(dbit)) & MASK;
                    3'd3: d = (d >> 1) | (int'(dbit) << (N - 1));
                    3'd4: d = ((d << 1) | (d >> (N - 1))) & MASK;
                    3'd5: d = (d >> 1) | ((d & 1) << (N - 1));
                    3'd6: d = (d >> 1) | (d & (1 << (N - 1)));
                    3'd7: begin
                        if (cnt == 0) dn = 1'b1;
                        else begin
                            l  = int'(cnt);
                            dr = bdir;
                        end
                    end
                    default: ;
                endcase
            end
            m_data <= d;
            m_left <= l;
            m_dir  <= dr;
            m_done <= dn;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (clr_n) begin
            chk("model data_out", 32'(data_out), 32'(m_data));
            chk("model busy", 32'(busy), 32'(m_left > 0));
            chk("model done", 32'(done), 32'(m_done));
            chk("model sout_l", 32'(sout_l), 32'((m_data >> (N - 1)) & 1));
            chk("model sout_r", 32'(sout_r), 32'(m_data & 1));
        end
    end

    // Drive one cycle of inputs at a negedge, return at the next negedge
    task automatic apply(input logic [2:0] o, input logic [7:0] d, input logic b,
                         input logic [3:0] c, input logic bd, input logic ab);
        op = o; data_in = d; dbit = b; cnt = c; bdir = bd; abort = ab;
        @(negedge clk);
    endtask

    task automatic op_check(input string name, input logic [2:0] o, input logic b,
                            input logic [7:0] exp);
        apply(3'd1, 8'h96, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(o, 8'h00, b, 4'd0, 1'b0, 1'b0);
        chk(name, 32'(data_out), 32'(exp));
        chk({name, " sout_l"}, 32'(sout_l), 32'(exp[7]));
        chk({name, " sout_r"}, 32'(sout_r), 32'(exp[0]));
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [7:0] end_val;
        int guard;

        clr_n = 1'b0; op = 3'd0; data_in = '0; dbit = 1'b0;
        cnt = '0; bdir = 1'b0; abort = 1'b0;
        #12 clr_n = 1'b1;
        @(negedge clk);
        chk("reset data_out", 32'(data_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);

        // Reset mid-burst is asynchronous
        apply(3'd1, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(3'd7, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0);
        apply(3'd0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("pre-reset busy", 32'(busy), 32'h1);
        #2 clr_n = 1'b0;
        #1;
        chk("async rst data_out", 32'(data_out), 32'h0);
        chk("async rst busy", 32'(busy), 32'h0);
        chk("async rst done", 32'(done), 32'h0);
        @(negedge clk);
        chk("held rst data_out", 32'(data_out), 32'h0);
        clr_n = 1'b1;
        apply(3'd1, 8'h3C, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("load after reset", 32'(data_out), 32'h3C);

        // Single-cycle ops from 0x96
        op_check("rotl", 3'd4, 1'b0, 8'h2D);
        op_check("rotr", 3'd5, 1'b0, 8'h4B);
        op_check("asr",  3'd6, 1'b0, 8'hCB);
        op_check("shl",  3'd2, 1'b0, 8'h2C);
        op_check("shr",  3'd3, 1'b1, 8'hCB);
        op_check("hold", 3'd0, 1'b1, 8'h96);

        // Left burst of 3 with loads attempted during RUN
        apply(3'd1, 8'h81, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(3'd7, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0);
        chk("burst start no change", 32'(data_out), 32'h81);
        busy_cnt = 0; done_cnt = 0; end_val = 8'h00;
        for (int i = 0; i < 7; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                end_val = data_out;
            end
            if (busy) apply(3'd1, 8'hFF, 1'b1, 4'd0, 1'b0, 1'b0);
            else      apply(3'd0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        end
        chk("left burst busy cycles", 32'(busy_cnt), 32'd3);
        chk("left burst done cycles", 32'(done_cnt), 32'd1);
        chk("left burst result", 32'(end_val), 32'h0F);
        chk("left burst held", 32'(data_out), 32'h0F);

        // Zero-length burst
        apply(3'd1, 8'h55, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(3'd7, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("zero burst done", 32'(done), 32'h1);
        chk("zero burst busy", 32'(busy), 32'h0);
        chk("zero burst data", 32'(data_out), 32'h55);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("zero burst done clears", 32'(done), 32'h0);

        // Abort after first right shift
        apply(3'd1, 8'hF0, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(3'd7, 8'h00, 1'b0, 4'd5, 1'b1, 1'b0);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("abort first shift", 32'(data_out), 32'h78);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("abort data", 32'(data_out), 32'h78);
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort done", 32'(done), 32'h0);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("abort done later", 32'(done), 32'h0);

        // Abort coinciding with the final step
        apply(3'd1, 8'h33, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(3'd7, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0);
        apply(3'd0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
        chk("final abort data", 32'(data_out), 32'h33);
        chk("final abort busy", 32'(busy), 32'h0);
        chk("final abort done", 32'(done), 32'h0);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("final abort done later", 32'(done), 32'h0);

        // Abort ignored in IDLE
        apply(3'd1, 8'hC3, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("idle abort ignored", 32'(data_out), 32'hC3);

        // Burst longer than n, right, filling ones
        apply(3'd1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(3'd7, 8'h00, 1'b1, 4'd10, 1'b1, 1'b0);
        guard = 0;
        while (!done && guard < 20) begin
            apply(3'd0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
            guard++;
        end
        chk("long burst finished", 32'(guard < 20), 32'h1);
        chk("long burst steps", 32'(guard), 32'd10);
        chk("long burst result", 32'(data_out), 32'hFF);

        // Back-to-back: new start on the done cycle
        apply(3'd7, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0);
        chk("b2b busy", 32'(busy), 32'h1);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("b2b done", 32'(done), 32'h1);
        chk("b2b result", 32'(data_out), 32'hFC);
        apply(3'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
